// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : RV32I ID/EX boundary. Decodes opcode/funct3/funct7 into a 4-bit
//             ALU opcode, selects ALU operands (rs1/PC, rs2/immediate) and
//             registers the result into the ID/EX pipeline register with
//             valid, stall and flush control.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_I,
  input  logic            rstn_I,
  input  logic            valid_I,
  input  logic [31:0]     instr_I,
  input  logic [XLEN-1:0] pc_I,
  input  logic [XLEN-1:0] rs1Data_I,
  input  logic [XLEN-1:0] rs2Data_I,
  input  logic            stall_I,
  input  logic            flush_I,
  output logic            ready_O,
  output logic            valid_O,
  output logic [XLEN-1:0] regA_O,
  output logic [XLEN-1:0] regB_O,
  output logic [3:0]      aluOP_O,
  output logic [4:0]      rd_O,
  output logic            regWrite_O,
  output logic [XLEN-1:0] storeData_O,
  output logic            illegal_O
);

  // ALU opcode encoding seen by the downstream ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRA  = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  // Major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr_I[6:0];
  assign funct3 = instr_I[14:12];
  assign funct7 = instr_I[31:25];
  assign rd     = instr_I[11:7];

  // Immediates, sign-extended to the datapath width
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;

  assign imm_i = {{(XLEN-12){instr_I[31]}}, instr_I[31:20]};
  assign imm_s = {{(XLEN-12){instr_I[31]}}, instr_I[31:25], instr_I[11:7]};
  assign imm_u = {{(XLEN-32){instr_I[31]}}, instr_I[31:12], 12'b0};

  // funct3 to ALU opcode for OP / OP-IMM, using the base (funct7=0) variant
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Decoded (pre-register) values
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic            dec_write;
  logic            dec_illegal;

  // Decode opcode/funct fields into ALU opcode, operands and write enable
  always_comb begin
    dec_op      = ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    dec_write   = 1'b1;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_a = rs1Data_I;
        dec_b = rs2Data_I;
        if (funct7 == F7_BASE) begin
          dec_op = base_op(funct3);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_op = ALU_SRA;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        // B keeps the whole immediate even for shifts; the ALU uses B[4:0]
        dec_a  = rs1Data_I;
        dec_b  = imm_i;
        dec_op = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            dec_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            dec_illegal = 1'b1;
          end
        end
      end

      OPC_LUI: begin
        dec_b = imm_u;
      end

      OPC_AUIPC: begin
        dec_a = pc_I;
        dec_b = imm_u;
      end

      OPC_LOAD: begin
        dec_a = rs1Data_I;
        dec_b = imm_i;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec_illegal = 1'b1;
        end
      end

      OPC_STORE: begin
        dec_a     = rs1Data_I;
        dec_b     = imm_s;
        dec_write = 1'b0;
        if (funct3 > 3'b010) begin
          dec_illegal = 1'b1;
        end
      end

      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // Unsupported encodings travel down as a NOP flagged illegal; the trap
    // decision belongs to a later stage
    if (dec_illegal) begin
      dec_op    = ALU_NOP;
      dec_a     = '0;
      dec_b     = '0;
      dec_write = 1'b0;
    end

    // x0 is never written
    if (rd == 5'd0) begin
      dec_write = 1'b0;
    end
  end

  // Upstream may present a new instruction whenever the register is not held
  assign ready_O = !stall_I;

  // ID/EX pipeline register: flush > stall > capture > bubble
  always_ff @(posedge clk_I or negedge rstn_I) begin
    if (!rstn_I) begin
      valid_O     <= 1'b0;
      regA_O      <= '0;
      regB_O      <= '0;
      aluOP_O     <= 4'd0;
      rd_O        <= 5'd0;
      regWrite_O  <= 1'b0;
      storeData_O <= '0;
      illegal_O   <= 1'b0;
    end else if (flush_I || (!stall_I && !valid_I)) begin
      valid_O     <= 1'b0;
      regA_O      <= '0;
      regB_O      <= '0;
      aluOP_O     <= 4'd0;
      rd_O        <= 5'd0;
      regWrite_O  <= 1'b0;
      storeData_O <= '0;
      illegal_O   <= 1'b0;
    end else if (!stall_I) begin
      valid_O     <= 1'b1;
      regA_O      <= dec_a;
      regB_O      <= dec_b;
      aluOP_O     <= dec_op;
      rd_O        <= rd;
      regWrite_O  <= dec_write;
      storeData_O <= rs2Data_I;
      illegal_O   <= dec_illegal;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Scoreboard bench for alu_issue_stage; directed RV32I vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] sd;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;

  logic        ready_out;
  logic        valid_out;
  logic [31:0] reg_a;
  logic [31:0] reg_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd_out;
  logic        reg_write;
  logic [31:0] store_data;
  logic        illegal_out;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  alu_issue_stage #(.XLEN(32)) dut (
    .clk_I       (clk),
    .rstn_I      (rstn),
    .valid_I     (valid_in),
    .instr_I     (instr),
    .pc_I        (pc),
    .rs1Data_I   (rs1),
    .rs2Data_I   (rs2),
    .stall_I     (stall),
    .flush_I     (flush),
    .ready_O     (ready_out),
    .valid_O     (valid_out),
    .regA_O      (reg_a),
    .regB_O      (reg_b),
    .aluOP_O     (alu_op),
    .rd_O        (rd_out),
    .regWrite_O  (reg_write),
    .storeData_O (store_data),
    .illegal_O   (illegal_out)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t r;
    r = '{valid: valid_out, a: reg_a, b: reg_b, op: alu_op, rd: rd_out,
          rw: reg_write, sd: store_data, ill: illegal_out};
    return r;
  endfunction

  function automatic exp_t mk(input logic v, input logic [31:0] a, b,
                              input logic [3:0] op, input logic [4:0] rd,
                              input logic rw, input logic [31:0] sd,
                              input logic ill);
    exp_t r;
    r = '{valid: v, a: a, b: b, op: op, rd: rd, rw: rw, sd: sd, ill: ill};
    return r;
  endfunction

  task automatic compare(input string name, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got v=%0b A=%h B=%h op=%0d rd=%0d rw=%0b sd=%h ill=%0b, want v=%0b A=%h B=%h op=%0d rd=%0d rw=%0b sd=%h ill=%0b",
               name, got.valid, got.a, got.b, got.op, got.rd, got.rw, got.sd, got.ill,
               want.valid, want.a, want.b, want.op, want.rd, want.rw, want.sd, want.ill);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the register
  // contents expected after the following rising edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    valid_in = v;
    instr    = ins;
    pc       = p;
    rs1      = r1;
    rs2      = r2;
    stall    = st;
    flush    = fl;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the registered outputs once per edge that has a queued expectation
  initial begin
    exp_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        compare("pipe", actual(), want);
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus, want finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero;
    exp_t held;
    zero = '0;

    // Reset asserted: everything cleared
    repeat (3) @(posedge clk);
    #1;
    compare("reset", actual(), zero);

    @(negedge clk);
    rstn = 1'b1;

    // Bubble after reset
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, zero);
    // add x3,x1,x2
    step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0,
         mk(1, 32'd5, 32'd7, 4'd0, 5'd3, 1, 32'd7, 0));
    // sub x3,x1,x2
    step(1'b1, 32'h402081B3, 32'h4, 32'd5, 32'd7, 1'b0, 1'b0,
         mk(1, 32'd5, 32'd7, 4'd1, 5'd3, 1, 32'd7, 0));
    // srai x5,x6,4 : B carries full immediate 0x404
    step(1'b1, 32'h40435293, 32'h8, 32'h80000000, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h80000000, 32'h00000404, 4'd3, 5'd5, 1, 32'h0, 0));
    // lui x7,0x12345
    step(1'b1, 32'h123453B7, 32'hC, 32'h55, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h0, 32'h12345000, 4'd0, 5'd7, 1, 32'h0, 0));
    // auipc x1,1 at pc 0x100
    step(1'b1, 32'h00001097, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h100, 32'h1000, 4'd0, 5'd1, 1, 32'h0, 0));
    // sw x2,8(x1)
    step(1'b1, 32'h0020A423, 32'h104, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0,
         mk(1, 32'h200, 32'h8, 4'd0, 5'd8, 0, 32'hDEADBEEF, 0));
    // OP with funct7=1111111: illegal
    step(1'b1, 32'hFE000033, 32'h108, 32'h1, 32'h2, 1'b0, 1'b0,
         mk(1, 32'h0, 32'h0, 4'd15, 5'd0, 0, 32'h2, 1));
    // addi x4,x0,-1 : negative immediate
    step(1'b1, 32'hFFF00213, 32'h10C, 32'h3, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h3, 32'hFFFFFFFF, 4'd0, 5'd4, 1, 32'h0, 0));
    // add x0,x1,x2 : write to x0 suppressed
    step(1'b1, 32'h00208033, 32'h110, 32'h1, 32'h2, 1'b0, 1'b0,
         mk(1, 32'h1, 32'h2, 4'd0, 5'd0, 0, 32'h2, 0));
    // slli with funct7=0100000: illegal
    step(1'b1, 32'h40209093, 32'h114, 32'h1, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h0, 32'h0, 4'd15, 5'd1, 0, 32'h0, 1));
    // lw x5,-4(x2)
    step(1'b1, 32'hFFC12283, 32'h118, 32'h1000, 32'h0, 1'b0, 1'b0,
         mk(1, 32'h1000, 32'hFFFFFFFC, 4'd0, 5'd5, 1, 32'h0, 0));
    // sra x3,x1,x2
    step(1'b1, 32'h4020D1B3, 32'h11C, 32'hF0, 32'h4, 1'b0, 1'b0,
         mk(1, 32'hF0, 32'h4, 4'd3, 5'd3, 1, 32'h4, 0));
    // sltu x3,x1,x2
    step(1'b1, 32'h0020B1B3, 32'h120, 32'h1, 32'h2, 1'b0, 1'b0,
         mk(1, 32'h1, 32'h2, 4'd9, 5'd3, 1, 32'h2, 0));
    // Unknown opcode
    step(1'b1, 32'h0000007F, 32'h124, 32'h1, 32'h2, 1'b0, 1'b0,
         mk(1, 32'h0, 32'h0, 4'd15, 5'd0, 0, 32'h2, 1));

    // Capture add, then stall three cycles while upstream changes
    held = mk(1, 32'd9, 32'd10, 4'd0, 5'd3, 1, 32'd10, 0);
    step(1'b1, 32'h002081B3, 32'h200, 32'd9, 32'd10, 1'b0, 1'b0, held);
    step(1'b1, 32'h402081B3, 32'h204, 32'd1, 32'd1, 1'b1, 1'b0, held);
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL ready_stall: got %0b, want 0", ready_out);
    end
    step(1'b0, 32'h123453B7, 32'h208, 32'd2, 32'd2, 1'b1, 1'b0, held);
    step(1'b1, 32'hFE000033, 32'h20C, 32'd3, 32'd3, 1'b1, 1'b0, held);
    // Stall and flush together: flush wins
    step(1'b1, 32'h002081B3, 32'h210, 32'd4, 32'd4, 1'b1, 1'b1, zero);

    // Capture, stall, then reset mid-stall clears at once
    step(1'b1, 32'h0020B1B3, 32'h300, 32'd6, 32'd8, 1'b0, 1'b0,
         mk(1, 32'd6, 32'd8, 4'd9, 5'd3, 1, 32'd8, 0));
    step(1'b1, 32'h402081B3, 32'h304, 32'd1, 32'd1, 1'b1, 1'b0,
         mk(1, 32'd6, 32'd8, 4'd9, 5'd3, 1, 32'd8, 0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    compare("reset_mid_stall", actual(), zero);
    @(negedge clk);
    rstn     = 1'b1;
    stall    = 1'b0;
    valid_in = 1'b0;
    // First capture after release
    step(1'b1, 32'h402081B3, 32'h308, 32'd20, 32'd3, 1'b0, 1'b0,
         mk(1, 32'd20, 32'd3, 4'd1, 5'd3, 1, 32'd3, 0));
    step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, zero);

    // Drain the scoreboard
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
